ped_request_arbiter: RTL and testbench

PED_REQUEST_ARBITER -- requirements
Module: ped_request_arbiter

---
 rtl/ped_request_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_ped_request_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ped_request_arbiter.sv
// rtl/ped_request_arbiter.sv - two-direction walk request arbiter with lockout; PED_DEFER_EN holds presses made during lockout
module ped_request_arbiter #(
    parameter int LOCKOUT_SEC = 10,
    parameter int WAIT_W      = 8
) (
    input  logic              clk_50_mhz,
    input  logic              reset,
    input  logic              tick_1_hz,
    input  logic              nrth_btn,
    input  logic              west_btn,
    input  logic              nrth_ack,
    input  logic              west_ack,
    output logic              nrth_req,
    output logic              west_req,
    output logic [WAIT_W-1:0] nrth_wait_sec,
    output logic [WAIT_W-1:0] west_wait_sec,
    output logic              first_west
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PENDING = 2'd1,
        S_LOCKOUT = 2'd2
    } state_t;

    localparam int LOCK_W = (LOCKOUT_SEC > 1) ? $clog2(LOCKOUT_SEC + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);
    localparam logic [LOCK_W-1:0] LOCK_ONE = LOCK_W'(1);
    localparam logic [LOCK_W-1:0] LOCK_INIT = LOCK_W'(LOCKOUT_SEC);

    // index 0 = north, index 1 = west
    logic [1:0]        btn;
    logic [1:0]        ack;
    logic [1:0]        prev_btn;
    logic              armed;
    logic [1:0]        btn_rise;
    logic [1:0]        enter;
    logic [1:0]        pend_q;
    logic [1:0]        pend_d;
    logic [WAIT_W-1:0] wait_all [2];
    logic              fw_d;

    assign btn = {west_btn, nrth_btn};
    assign ack = {west_ack, nrth_ack};

    // Edge registers; armed stays low for the first cycle after reset so a held button cannot fake an edge
    always_ff @(posedge clk_50_mhz or posedge reset) begin
        if (reset) begin
            prev_btn <= 2'b00;
            armed    <= 1'b0;
        end else begin
            prev_btn <= btn;
            armed    <= 1'b1;
        end
    end

    assign btn_rise = btn & ~prev_btn & {2{armed}};

    for (genvar d = 0; d < 2; d++) begin : g_dir
        state_t            state_q;
        state_t            state_d;
        logic [WAIT_W-1:0] wait_q;
        logic [WAIT_W-1:0] wait_d;
        logic [LOCK_W-1:0] lock_q;
        logic [LOCK_W-1:0] lock_d;
        logic              enter_l;
`ifdef PED_DEFER_EN
        logic              defer_q;
        logic              defer_d;
`endif

        // Next-state, counter and deferred-press logic for one direction
        always_comb begin
            state_d = state_q;
            wait_d  = wait_q;
            lock_d  = lock_q;
            enter_l = 1'b0;
`ifdef PED_DEFER_EN
            defer_d = defer_q;
`endif
            case (state_q)
                S_IDLE: begin
                    if (btn_rise[d]) begin
                        state_d = S_PENDING;
                        wait_d  = '0;
                        enter_l = 1'b1;
                    end
                end
                S_PENDING: begin
                    // ack outranks a coincident tick
                    if (ack[d]) begin
                        state_d = S_LOCKOUT;
                        lock_d  = LOCK_INIT;
                        wait_d  = '0;
                    end else if (tick_1_hz && (wait_q != '1)) begin
                        wait_d = wait_q + WAIT_ONE;
                    end
                end
                S_LOCKOUT: begin
                    if (lock_q == '0) begin
`ifdef PED_DEFER_EN
                        defer_d = 1'b0;
                        if (defer_q || btn_rise[d]) begin
                            state_d = S_PENDING;
                            wait_d  = '0;
                            enter_l = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                        end
`else
                        state_d = S_IDLE;
`endif
                    end else begin
                        if (tick_1_hz) begin
                            lock_d = lock_q - LOCK_ONE;
                        end
`ifdef PED_DEFER_EN
                        if (btn_rise[d]) begin
                            defer_d = 1'b1;
                        end
`endif
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        // State and counter registers for one direction
        always_ff @(posedge clk_50_mhz or posedge reset) begin
            if (reset) begin
                state_q <= S_IDLE;
                wait_q  <= '0;
                lock_q  <= '0;
`ifdef PED_DEFER_EN
                defer_q <= 1'b0;
`endif
            end else begin
                state_q <= state_d;
                wait_q  <= wait_d;
                lock_q  <= lock_d;
`ifdef PED_DEFER_EN
                defer_q <= defer_d;
`endif
            end
        end

        assign enter[d]    = enter_l;
        assign pend_q[d]   = (state_q == S_PENDING);
        assign pend_d[d]   = (state_d == S_PENDING);
        assign wait_all[d] = wait_q;
    end

    // Arrival order: only the later of two pending requests decides it; north wins a same-cycle tie
    always_comb begin
        fw_d = first_west;
        if (pend_d != 2'b11) begin
            fw_d = 1'b0;
        end else if (enter == 2'b11) begin
            fw_d = 1'b0;
        end else if (enter[0]) begin
            fw_d = 1'b1;
        end else if (enter[1]) begin
            fw_d = 1'b0;
        end
    end

    // Registered arrival-order flag
    always_ff @(posedge clk_50_mhz or posedge reset) begin
        if (reset) begin
            first_west <= 1'b0;
        end else begin
            first_west <= fw_d;
        end
    end

    assign nrth_req      = pend_q[0];
    assign west_req      = pend_q[1];
    assign nrth_wait_sec = wait_all[0];
    assign west_wait_sec = wait_all[1];

endmodule

// File: tb/tb_ped_request_arbiter.sv
// tb/tb_ped_request_arbiter.sv - randomized model-checked bench for ped_request_arbiter (lockout 10 and lockout 0 instances)
module tb_ped_request_arbiter;

`ifdef PED_DEFER_EN
    localparam bit DEFER = 1'b1;
`else
    localparam bit DEFER = 1'b0;
`endif
    localparam int MAXW = 15;

    logic clk_50_mhz = 1'b0;
    logic reset      = 1'b0;
    logic tick_1_hz  = 1'b0;
    logic nrth_btn   = 1'b0;
    logic west_btn   = 1'b0;
    logic nrth_ack   = 1'b0;
    logic west_ack   = 1'b0;

    logic       nreq  [2];
    logic       wreq  [2];
    logic       fw    [2];
    logic [3:0] nwait [2];
    logic [3:0] wwait [2];

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    always #5 clk_50_mhz = ~clk_50_mhz;

    ped_request_arbiter #(.LOCKOUT_SEC(10), .WAIT_W(4)) u0 (
        .clk_50_mhz(clk_50_mhz), .reset(reset), .tick_1_hz(tick_1_hz),
        .nrth_btn(nrth_btn), .west_btn(west_btn), .nrth_ack(nrth_ack), .west_ack(west_ack),
        .nrth_req(nreq[0]), .west_req(wreq[0]),
        .nrth_wait_sec(nwait[0]), .west_wait_sec(wwait[0]), .first_west(fw[0])
    );

    ped_request_arbiter #(.LOCKOUT_SEC(0), .WAIT_W(4)) u1 (
        .clk_50_mhz(clk_50_mhz), .reset(reset), .tick_1_hz(tick_1_hz),
        .nrth_btn(nrth_btn), .west_btn(west_btn), .nrth_ack(nrth_ack), .west_ack(west_ack),
        .nrth_req(nreq[1]), .west_req(wreq[1]),
        .nrth_wait_sec(nwait[1]), .west_wait_sec(wwait[1]), .first_west(fw[1])
    );

    // Behavioural model, indexed [instance][direction], direction 0 = north, 1 = west.
    // m_lock = -1 means "not locked out", otherwise seconds of lockout left.
    // m_since orders arrivals: 2*cycle + direction, so north sorts first on a tie.
    bit m_pend  [2][2];
    int m_wait  [2][2];
    int m_lock  [2][2];
    bit m_def   [2][2];
    int m_since [2][2];
    bit m_prev  [2];
    bit m_armed;
    int mcyc;

    function automatic int lsec(input int i);
        return (i == 0) ? 10 : 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            for (int d = 0; d < 2; d++) begin
                m_pend[i][d]  = 1'b0;
                m_wait[i][d]  = 0;
                m_lock[i][d]  = -1;
                m_def[i][d]   = 1'b0;
                m_since[i][d] = 0;
            end
        end
        m_prev[0] = 1'b0;
        m_prev[1] = 1'b0;
        m_armed   = 1'b0;
    endtask

    task automatic model_step();
        bit b [2];
        bit a [2];
        bit rise [2];
        bit ent;
        b[0] = nrth_btn;
        b[1] = west_btn;
        a[0] = nrth_ack;
        a[1] = west_ack;
        for (int d = 0; d < 2; d++) rise[d] = b[d] && !m_prev[d] && m_armed;
        for (int i = 0; i < 2; i++) begin
            for (int d = 0; d < 2; d++) begin
                ent = 1'b0;
                if (m_pend[i][d]) begin
                    if (a[d]) begin
                        m_pend[i][d] = 1'b0;
                        m_wait[i][d] = 0;
                        m_lock[i][d] = lsec(i);
                    end else if (tick_1_hz && m_wait[i][d] < MAXW) begin
                        m_wait[i][d] = m_wait[i][d] + 1;
                    end
                end else if (m_lock[i][d] >= 0) begin
                    if (m_lock[i][d] == 0) begin
                        m_lock[i][d] = -1;
                        ent = DEFER && (m_def[i][d] || rise[d]);
                        m_def[i][d] = 1'b0;
                    end else begin
                        if (tick_1_hz) m_lock[i][d] = m_lock[i][d] - 1;
                        if (DEFER && rise[d]) m_def[i][d] = 1'b1;
                    end
                end else begin
                    ent = rise[d];
                end
                if (ent) begin
                    m_pend[i][d]  = 1'b1;
                    m_wait[i][d]  = 0;
                    m_since[i][d] = 2 * mcyc + d;
                end
            end
        end
        m_prev[0] = b[0];
        m_prev[1] = b[1];
        m_armed   = 1'b1;
        mcyc      = mcyc + 1;
    endtask

    // Advance the model on the same events that clock or reset the DUT
    always @(posedge clk_50_mhz or posedge reset) begin
        if (reset) model_reset();
        else model_step();
    end

    task automatic check(input string nm, input int got, input int exp);
        total = total + 1;
        if (got != exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
        end
    endtask

    // Per-cycle comparison of every output of both instances against the model
    always @(posedge clk_50_mhz) begin
        #3;
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                check($sformatf("u%0d nrth_req", i), int'(nreq[i]), int'(m_pend[i][0]));
                check($sformatf("u%0d west_req", i), int'(wreq[i]), int'(m_pend[i][1]));
                check($sformatf("u%0d nrth_wait", i), int'(nwait[i]), m_wait[i][0]);
                check($sformatf("u%0d west_wait", i), int'(wwait[i]), m_wait[i][1]);
                check($sformatf("u%0d first_west", i), int'(fw[i]),
                      int'(m_pend[i][0] && m_pend[i][1] && (m_since[i][1] < m_since[i][0])));
            end
        end
    end

    task automatic cyc(input bit nb, input bit wb, input bit na, input bit wa, input bit tk);
        @(negedge clk_50_mhz);
        nrth_btn  = nb;
        west_btn  = wb;
        nrth_ack  = na;
        west_ack  = wa;
        tick_1_hz = tk;
        @(posedge clk_50_mhz);
        #4;
    endtask

    // Buttons keep their current level through reset
    task automatic do_reset();
        @(negedge clk_50_mhz);
        reset     = 1'b1;
        nrth_ack  = 1'b0;
        west_ack  = 1'b0;
        tick_1_hz = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            check("rst nrth_req", int'(nreq[i]), 0);
            check("rst west_req", int'(wreq[i]), 0);
            check("rst nrth_wait", int'(nwait[i]), 0);
            check("rst west_wait", int'(wwait[i]), 0);
            check("rst first_west", int'(fw[i]), 0);
        end
        @(negedge clk_50_mhz);
        @(negedge clk_50_mhz);
        reset = 1'b0;
    endtask

    initial begin
        int rises;
        bit pw;
        bit nb;
        bit wb;
        bit tk;
        mcyc = 0;
        model_reset();
        #1 reset = 1'b1;
        chk_en = 1'b1;

        // North press, three ticks, ack
        do_reset();
        cyc(1, 0, 0, 0, 0);
        check("press nrth_req", int'(nreq[0]), 1);
        check("press nrth_wait", int'(nwait[0]), 0);
        for (int k = 1; k <= 3; k++) begin
            cyc(1, 0, 0, 0, 1);
            check("tick nrth_wait", int'(nwait[0]), k);
        end
        cyc(1, 0, 1, 0, 0);
        check("ack nrth_req", int'(nreq[0]), 0);
        check("ack nrth_wait", int'(nwait[0]), 0);

        // Zero-length lockout frees u1 at once; the same press lands in u0's lockout
        cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        check("lock0 nrth_req", int'(nreq[1]), 1);
        check("lock10 nrth_req", int'(nreq[0]), 0);
        for (int k = 1; k <= 10; k++) cyc(1, 0, 0, 0, 1);
        check("lock10 held", int'(nreq[0]), 0);
        check("lock0 wait10", int'(nwait[1]), 10);
        cyc(1, 0, 0, 0, 0);
        check("defer exit", int'(nreq[0]), int'(DEFER));
        for (int k = 0; k < 8; k++) cyc(1, 0, 0, 0, 1);
        check("wait saturate", int'(nwait[1]), 15);

        // West first, north five cycles later, then west served
        cyc(0, 0, 0, 0, 0);
        do_reset();
        for (int k = 0; k < 5; k++) cyc(0, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        check("order first_west", int'(fw[0]), 1);
        check("order first_west u1", int'(fw[1]), 1);
        cyc(1, 1, 0, 1, 0);
        check("served first_west", int'(fw[0]), 0);
        check("served west_req", int'(wreq[0]), 0);
        check("served nrth_req", int'(nreq[0]), 1);

        // Simultaneous presses, then ack coinciding with a tick
        cyc(0, 0, 0, 0, 0);
        do_reset();
        cyc(1, 1, 0, 0, 0);
        check("tie nrth_req", int'(nreq[0]), 1);
        check("tie west_req", int'(wreq[0]), 1);
        check("tie first_west", int'(fw[0]), 0);
        cyc(1, 1, 0, 0, 1);
        cyc(1, 1, 1, 1, 1);
        check("acktick nrth_wait", int'(nwait[0]), 0);
        check("acktick west_wait", int'(wwait[0]), 0);
        check("acktick nrth_req", int'(nreq[0]), 0);

        // Reset in PENDING with wait 7, button held through release
        cyc(0, 0, 0, 0, 0);
        do_reset();
        cyc(1, 0, 0, 0, 0);
        for (int k = 0; k < 7; k++) cyc(1, 0, 0, 0, 1);
        check("pre-reset wait", int'(nwait[0]), 7);
        do_reset();
        for (int k = 0; k < 3; k++) cyc(1, 0, 0, 0, 1);
        check("held-reset u0", int'(nreq[0]), 0);
        check("held-reset u1", int'(nreq[1]), 0);

        // West held for 1000 cycles with one ack: exactly one request
        cyc(0, 0, 0, 0, 0);
        do_reset();
        rises = 0;
        pw = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            cyc(0, 1, 0, (k == 20), ($urandom_range(0, 3) == 0));
            if (wreq[0] && !pw) rises = rises + 1;
            pw = wreq[0];
        end
        check("held west requests", rises, 1);

        // Randomized traffic, with tick bursts to reach saturation
        cyc(0, 0, 0, 0, 0);
        do_reset();
        nb = 1'b0;
        wb = 1'b0;
        for (int k = 0; k < 5000; k++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
            end else begin
                if ($urandom_range(0, 7) == 0) nb = ~nb;
                if ($urandom_range(0, 7) == 0) wb = ~wb;
                tk = ((k % 500) < 120) ? 1'b1 : ($urandom_range(0, 3) == 0);
                cyc(nb, wb, ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0), tk);
            end
        end

        cyc(0, 0, 0, 0, 0);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
